// File: rtl/fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arbiter
// Description : Four-lane round-robin arbiter that pops upstream FIFOs and
//               pushes one word per cycle into a downstream FIFO (2-cycle lat).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic [LANES-1:0]            fifo_empty,
    input  logic [LANES*DATA_WIDTH-1:0] fifo_data_in,
    input  logic                        pausa,
    output logic [LANES-1:0]            pop,
    output logic                        push,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [1:0]                  lane_out,
    output logic                        idle
);

    logic [1:0]            last_q, last_d;
    logic [LANES-1:0]      pop_q, pop_d;
    logic                  cap_valid_q;
    logic [1:0]            cap_lane_q;
    logic [DATA_WIDTH-1:0] cap_data_q;
    logic                  push_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            lane_q;
    logic                  idle_q, idle_d;

    logic [LANES-1:0]      w_eligible;
    logic [1:0]            w_idx;
    logic [1:0]            w_cap_lane;
    logic [DATA_WIDTH-1:0] w_cap_data;

    // A lane popped last cycle is skipped so its lagging empty flag can settle.
    assign w_eligible = ~fifo_empty & ~pop_q & {LANES{~pausa}};

    always_comb begin
        pop_d  = '0;
        last_d = last_q;
        w_idx  = last_q;
        for (int k = 1; k <= LANES; k++) begin
            w_idx = last_q + 2'(k);
            if ((pop_d == '0) && w_eligible[w_idx]) begin
                pop_d[w_idx] = 1'b1;
                last_d       = w_idx;
            end
        end
    end

    always_comb begin
        w_cap_lane = 2'd0;
        w_cap_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pop_q[i]) begin
                w_cap_lane = 2'(i);
                w_cap_data = fifo_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Idle is registered alongside the stage it describes, so it looks ahead one stage.
    assign idle_d = (pop_d == '0) && !(|pop_q) && !cap_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            last_q      <= 2'd3;
            pop_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_lane_q  <= 2'd0;
            cap_data_q  <= '0;
            push_q      <= 1'b0;
            data_q      <= '0;
            lane_q      <= 2'd0;
            idle_q      <= 1'b1;
        end else begin
            last_q      <= last_d;
            pop_q       <= pop_d;
            cap_valid_q <= |pop_q;
            cap_lane_q  <= w_cap_lane;
            cap_data_q  <= w_cap_data;
            push_q      <= cap_valid_q;
            data_q      <= cap_data_q;
            lane_q      <= cap_lane_q;
            idle_q      <= idle_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign data_out = data_q;
    assign lane_out = lane_q;
    assign idle     = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_arbiter
// Description : Directed vector table plus hand sequences for fifo_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [3:0]    fifo_empty;
    logic [4*DW-1:0] fifo_data_in;
    logic          pausa;
    logic [3:0]    pop;
    logic          push;
    logic [DW-1:0] data_out;
    logic [1:0]    lane_out;
    logic          idle;

    int total = 0;
    int bad   = 0;

    fifo_arbiter #(.DATA_WIDTH(DW), .LANES(4)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .fifo_empty   (fifo_empty),
        .fifo_data_in (fifo_data_in),
        .pausa        (pausa),
        .pop          (pop),
        .push         (push),
        .data_out     (data_out),
        .lane_out     (lane_out),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] empty;
        logic       pausa;
        logic [3:0] pop;
        logic       push;
        logic [5:0] data;
        logic [1:0] lane;
        logic       idle;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic p,
                                input logic [3:0] ep, input logic eu, input logic [5:0] ed,
                                input logic [1:0] el, input logic ei);
        vec_t v;
        v.rst_n = r;  v.empty = e;  v.pausa = p;  v.pop = ep;
        v.push  = eu; v.data  = ed; v.lane  = el; v.idle = ei;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_cycle(input logic r, input logic [3:0] e, input logic p);
        reset_L    = r;
        fifo_empty = e;
        pausa      = p;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] hist[0:8];
    logic [3:0] exp_pop;
    logic       exp_push;

    initial begin
        reset_L      = 1'b0;
        fifo_empty   = 4'b1111;
        pausa        = 1'b0;
        fifo_data_in = {6'h34, 6'h23, 6'h12, 6'h01};

        // Reset, full round-robin sweep, drain
        vt[0]  = mk(0, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 1);
        vt[1]  = mk(1, 4'b0000, 0, 4'b0001, 0, 6'h00, 2'd0, 0);
        vt[2]  = mk(1, 4'b0000, 0, 4'b0010, 0, 6'h00, 2'd0, 0);
        vt[3]  = mk(1, 4'b0000, 0, 4'b0100, 1, 6'h01, 2'd0, 0);
        vt[4]  = mk(1, 4'b0000, 0, 4'b1000, 1, 6'h12, 2'd1, 0);
        vt[5]  = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h23, 2'd2, 0);
        vt[6]  = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h34, 2'd3, 0);
        vt[7]  = mk(1, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 1);
        // Pausa after two grants, then resume from lane 2
        vt[8]  = mk(0, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 1);
        vt[9]  = mk(1, 4'b0000, 0, 4'b0001, 0, 6'h00, 2'd0, 0);
        vt[10] = mk(1, 4'b0000, 0, 4'b0010, 0, 6'h00, 2'd0, 0);
        vt[11] = mk(1, 4'b0000, 1, 4'b0000, 1, 6'h01, 2'd0, 0);
        vt[12] = mk(1, 4'b0000, 1, 4'b0000, 1, 6'h12, 2'd1, 0);
        vt[13] = mk(1, 4'b0000, 1, 4'b0000, 0, 6'h00, 2'd0, 1);
        vt[14] = mk(1, 4'b0000, 1, 4'b0000, 0, 6'h00, 2'd0, 1);
        vt[15] = mk(1, 4'b0000, 0, 4'b0100, 0, 6'h00, 2'd0, 0);
        vt[16] = mk(1, 4'b0000, 0, 4'b1000, 0, 6'h00, 2'd0, 0);
        vt[17] = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h23, 2'd2, 0);
        vt[18] = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h34, 2'd3, 0);
        vt[19] = mk(1, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 1);
        // Last grant = 1, then lanes 1 and 3 compete
        vt[20] = mk(1, 4'b1101, 0, 4'b0010, 0, 6'h00, 2'd0, 0);
        vt[21] = mk(1, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 0);
        vt[22] = mk(1, 4'b0101, 0, 4'b1000, 1, 6'h12, 2'd1, 0);
        vt[23] = mk(1, 4'b0101, 0, 4'b0010, 0, 6'h00, 2'd0, 0);
        vt[24] = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h34, 2'd3, 0);
        vt[25] = mk(1, 4'b1111, 0, 4'b0000, 1, 6'h12, 2'd1, 0);
        vt[26] = mk(1, 4'b1111, 0, 4'b0000, 0, 6'h00, 2'd0, 1);

        for (int i = 0; i < 27; i++) begin
            do_cycle(vt[i].rst_n, vt[i].empty, vt[i].pausa);
            check("pop",  i, 32'(pop),  32'(vt[i].pop));
            check("push", i, 32'(push), 32'(vt[i].push));
            check("idle", i, 32'(idle), 32'(vt[i].idle));
            if (vt[i].push || !vt[i].rst_n) begin
                check("data_out", i, 32'(data_out), 32'(vt[i].data));
                check("lane_out", i, 32'(lane_out), 32'(vt[i].lane));
            end
        end

        // All lanes empty for 10 cycles
        do_cycle(0, 4'b1111, 0);
        for (int k = 0; k < 10; k++) begin
            do_cycle(1, 4'b1111, 0);
            check("empty_pop",  k, 32'(pop),  32'd0);
            check("empty_push", k, 32'(push), 32'd0);
            check("empty_idle", k, 32'(idle), 32'd1);
        end

        // Single non-empty lane 2: pops on alternate cycles only
        do_cycle(0, 4'b1111, 0);
        hist[0] = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            do_cycle(1, (k <= 6) ? 4'b1011 : 4'b1111, 0);
            exp_pop  = (k <= 6 && (k % 2) == 1) ? 4'b0100 : 4'b0000;
            hist[k]  = exp_pop;
            exp_push = (k >= 3) && (hist[k-2] != 4'b0000);
            check("single_pop",  k, 32'(pop),  32'(exp_pop));
            check("single_push", k, 32'(push), 32'(exp_push));
            if (exp_push) begin
                check("single_lane", k, 32'(lane_out), 32'd2);
                check("single_data", k, 32'(data_out), 32'h23);
            end
        end

        // Reset with two words in flight
        do_cycle(0, 4'b1111, 0);
        do_cycle(1, 4'b0000, 0);
        check("rst_pre_pop", 0, 32'(pop), 32'b0001);
        do_cycle(1, 4'b0000, 0);
        check("rst_pre_pop", 1, 32'(pop), 32'b0010);
        do_cycle(0, 4'b0000, 0);
        check("rst_push", 0, 32'(push), 32'd0);
        check("rst_pop",  0, 32'(pop),  32'd0);
        check("rst_idle", 0, 32'(idle), 32'd1);
        do_cycle(1, 4'b0000, 0);
        check("rst_push", 1, 32'(push), 32'd0);
        check("rst_pop",  1, 32'(pop),  32'b0001);
        do_cycle(1, 4'b0000, 0);
        check("rst_push", 2, 32'(push), 32'd0);
        check("rst_pop",  2, 32'(pop),  32'b0010);
        do_cycle(1, 4'b1111, 0);
        check("rst_post_push", 0, 32'(push),     32'd1);
        check("rst_post_data", 0, 32'(data_out), 32'h01);
        check("rst_post_lane", 0, 32'(lane_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 6: word width of every lane and of the output.
REQ-002 Parameter LANES, default 4: number of upstream FIFO lanes; the block supports only the value 4.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_L, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port fifo_empty, input, LANES: per-lane Fifo_Empty from the upstream FIFOs; bit i belongs to lane i.
REQ-006 Port fifo_data_in, input, LANES*DATA_WIDTH: per-lane Fifo_Data_out; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port pausa, input, 1: Pausa from the downstream FIFO; 1 forbids issuing new pops.
REQ-008 Port pop, output, LANES: registered, one-hot-or-zero pop strobe to the upstream FIFOs.
REQ-009 Port push, output, 1: registered push strobe to the downstream FIFO.
REQ-010 Port data_out, output, DATA_WIDTH: registered word to the downstream FIFO; meaningful only while push=1.
REQ-011 Port lane_out, output, 2: registered index of the lane that sourced data_out; meaningful only while push=1.
REQ-012 Port idle, output, 1: registered; 1 when no pop and no push is in flight.

Function
REQ-013 Pipeline: a grant in cycle n drives pop[i]=1 in cycle n. Lane i data is valid on fifo_data_in during cycle n+1 and is captured at the end of n+1. The block drives push=1, data_out and lane_out=i in cycle n+2, so fixed latency is 2 cycles from pop to push.
REQ-014 Eligibility: lane i is eligible in a cycle when fifo_empty[i]=0, pausa=0, and lane i did not have pop[i]=1 in the previous cycle.
REQ-015 Arbitration: round-robin. The search starts at the lane after the last granted lane (modulo 4) and grants the first eligible lane found. The last-grant pointer updates only on a grant.
REQ-016 At most one pop bit is high per cycle; pop is 0 when no lane is eligible.
REQ-017 Throughput: with 2 or more non-empty lanes and pausa=0, the block grants one pop every cycle (back-to-back, alternating lanes).
REQ-018 Single non-empty lane: that lane receives pops only on alternating cycles, giving its lagging empty flag one cycle to settle.
REQ-019 pausa=1 blocks new grants from the same cycle onward. Pops already issued (at most 2 words in flight) still complete as pushes; no in-flight word is dropped.
REQ-020 The capture stage copies data unchanged. push in cycle n+2 equals pop activity in cycle n; push is 0 in cycles with no corresponding pop.
REQ-021 idle=1 exactly when pop=0 and no word is in the capture stage or output stage.
REQ-022 State: last-grant pointer (2 bits), previous-pop vector (LANES bits), capture valid flag + lane + data, output registers. No other storage.

Reset
REQ-023 While reset_L=0 at a rising edge, the next-cycle values are: pop=0, push=0, data_out=0, lane_out=0, idle=1, capture valid=0, previous-pop=0, last-grant pointer=3 (so lane 0 has first priority).
REQ-024 Reset asserted mid-operation discards every in-flight word: no push occurs in the cycles after reset, even for pops issued before reset.
REQ-025 The first grant can occur in the first cycle in which reset_L=1.

Verification
REQ-026 Reset, then lanes 0..3 all non-empty with words 0x01/0x12/0x23/0x34 and pausa=0 -> pop is 0001,0010,0100,1000 on consecutive cycles; push on cycles 3..6 with data 0x01,0x12,0x23,0x34 and lane_out 0,1,2,3.
REQ-027 Only lane 2 non-empty for 6 cycles -> pop=0100 on alternating cycles only; each push carries lane_out=2 and occurs exactly 2 cycles after its pop.
REQ-028 All lanes non-empty; pausa rises in the cycle after two grants -> no pop while pausa=1; exactly 2 more pushes; idle=1 two cycles later; pausa falls -> round-robin resumes from the lane after the last one granted.
REQ-029 reset_L=0 for one cycle while 2 words are in flight -> push stays 0 for the following 3 cycles; the next grant goes to lane 0.
REQ-030 All fifo_empty=1 for 10 cycles -> pop=0, push=0, idle=1 throughout.
REQ-031 Lanes 1 and 3 non-empty with last grant=1 -> next grant is lane 3, then lane 1.
